vector_issue_arb: RTL and testbench

Shares one vector issue port among 16 instruction requesters and one priority kap requester. Requesters use valid/ready handshakes. Selection is round-robin among the instruction channels; the kap channel has priority, bounded by a fairness cap. Each winner is latched into a single-entry output slot that drains to the issue port. The block sits between the per-instruction handshake fan-in of the vector controller and the vector execution pipe.

---
 rtl/vector_issue_arb.sv | 124 ++++++++++++
 tb/tb_vector_issue_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_arb.sv
// Issue-port arbiter: round-robin over instruction requesters, kap priority with a
// consecutive-grant cap, winner latched into a single-entry slot draining to the pipe.
//
// state      | meaning
// SLOT_EMPTY | no winner held; issue_valid low
// SLOT_FULL  | winner held in issue_id_q until issue_ready
module vector_issue_arb #(
   parameter int NREQ    = 16,
   parameter int KAP_MAX = 4,
   parameter int IDW     = $clog2(NREQ) + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            arb_en,
   input  logic [NREQ-1:0] instr_valid,
   output logic [NREQ-1:0] instr_ready,
   input  logic            kap_valid,
   output logic            kap_ready,
   output logic            issue_valid,
   output logic [IDW-1:0]  issue_id,
   input  logic            issue_ready
);

   localparam int PW = $clog2(NREQ);
   localparam int KW = $clog2(KAP_MAX + 1);
   localparam logic [PW:0]     NREQ_W    = (PW+1)'(NREQ);
   localparam logic [PW-1:0]   LAST_IDX  = PW'(NREQ - 1);
   localparam logic [KW-1:0]   KAP_MAX_W = KW'(KAP_MAX);
   localparam logic [IDW-1:0]  KAP_ID    = IDW'(NREQ);

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   slot_e           state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [KW-1:0]   kap_cnt_q, kap_cnt_d;
   logic [IDW-1:0]  issue_id_q, issue_id_d;

   logic            can_accept;
   logic            inst_pend;
   logic            kap_win;
   logic            inst_acc;
   logic [PW:0]     rr_sum;
   logic [PW-1:0]   rr_idx;
   logic [PW-1:0]   win_idx;
   logic            win_found;

   assign issue_valid = (state_q == SLOT_FULL);
   assign issue_id    = issue_id_q;

   assign can_accept = reset_n & arb_en & (~issue_valid | issue_ready);
   assign inst_pend  = |instr_valid;
   assign kap_win    = kap_valid & ((kap_cnt_q < KAP_MAX_W) | ~inst_pend);
   assign kap_ready  = can_accept & kap_win;
   assign inst_acc   = can_accept & ~kap_win & win_found;

   // Scan starts at ptr_q and wraps, so the channel just served is searched last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      rr_sum    = '0;
      rr_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (rr_sum >= NREQ_W) begin
            rr_sum = rr_sum - NREQ_W;
         end
         rr_idx = rr_sum[PW-1:0];
         if (!win_found && instr_valid[rr_idx]) begin
            win_found = 1'b1;
            win_idx   = rr_idx;
         end
      end
   end

   always_comb begin
      instr_ready = '0;
      if (inst_acc) begin
         instr_ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      kap_cnt_d  = kap_cnt_q;
      issue_id_d = issue_id_q;
      if (kap_ready) begin
         state_d    = SLOT_FULL;
         issue_id_d = KAP_ID;
         if (!inst_pend) begin
            kap_cnt_d = '0;
         end else if (kap_cnt_q >= KAP_MAX_W) begin
            kap_cnt_d = KAP_MAX_W;
         end else begin
            kap_cnt_d = kap_cnt_q + KW'(1);
         end
      end else if (inst_acc) begin
         state_d    = SLOT_FULL;
         issue_id_d = IDW'(win_idx);
         kap_cnt_d  = '0;
         ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
      end else if ((state_q == SLOT_FULL) && issue_ready) begin
         state_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= SLOT_EMPTY;
         ptr_q      <= '0;
         kap_cnt_q  <= '0;
         issue_id_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         kap_cnt_q  <= kap_cnt_d;
         issue_id_q <= issue_id_d;
      end
   end

endmodule

// File: tb/tb_vector_issue_arb.sv
// Scoreboard bench for vector_issue_arb: a driver models arbitration per cycle and queues
// expected winners; a monitor compares the issue slot against the queue.
module tb_vector_issue_arb;

   localparam int NREQ    = 16;
   localparam int KAP_MAX = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        arb_en = 1'b0;
   logic [15:0] instr_valid = '0;
   logic [15:0] instr_ready;
   logic        kap_valid = 1'b0;
   logic        kap_ready;
   logic        issue_valid;
   logic [4:0]  issue_id;
   logic        issue_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];

   int m_ptr  = 0;
   int m_kcnt = 0;
   bit m_full = 1'b0;

   int          acc;
   logic [15:0] rv;
   logic        rk;

   always #5 clk = ~clk;

   vector_issue_arb #(.NREQ(NREQ), .KAP_MAX(KAP_MAX)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .arb_en      (arb_en),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .kap_valid   (kap_valid),
      .kap_ready   (kap_ready),
      .issue_valid (issue_valid),
      .issue_id    (issue_id),
      .issue_ready (issue_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, check ready outputs against the model, advance the model.
   task automatic step(input logic [15:0] iv, input logic kv, input logic en,
                       input logic ir, output int a);
      int   w;
      int   i;
      bit   pend, kwin, can;
      logic [15:0] e_ir;
      logic e_kr;
      @(negedge clk);
      instr_valid = iv;
      kap_valid   = kv;
      arb_en      = en;
      issue_ready = ir;
      #1;
      pend = (iv != 16'h0);
      kwin = kv && ((m_kcnt < KAP_MAX) || !pend);
      can  = reset_n && en && (!m_full || ir);
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         i = (m_ptr + k) % NREQ;
         if (iv[i]) begin
            w = i;
            break;
         end
      end
      e_ir = '0;
      e_kr = 1'b0;
      a    = -1;
      chk("issue_valid", {31'b0, issue_valid}, {31'b0, m_full});
      if (can && kwin) begin
         e_kr   = 1'b1;
         a      = NREQ;
         m_kcnt = pend ? ((m_kcnt < KAP_MAX) ? m_kcnt + 1 : KAP_MAX) : 0;
      end else if (can && w >= 0) begin
         e_ir[w] = 1'b1;
         a       = w;
         m_ptr   = (w + 1) % NREQ;
         m_kcnt  = 0;
      end
      chk("instr_ready", {16'b0, instr_ready}, {16'b0, e_ir});
      chk("kap_ready", {31'b0, kap_ready}, {31'b0, e_kr});
      if (a >= 0) begin
         exp_q.push_back(a);
         m_full = 1'b1;
      end else if (m_full && ir) begin
         m_full = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
      chk("rst_kap_ready", {31'b0, kap_ready}, 32'd0);
      chk("rst_instr_ready", {16'b0, instr_ready}, 32'd0);
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      m_kcnt = 0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // Monitor: slot contents must match the queue head; pop on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset_n && issue_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL issue_id: got %0d with no expected entry (t=%0t)", issue_id, $time);
            end else begin
               chk("issue_id", {27'b0, issue_id}, exp_q[0]);
               if (issue_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      repeat (3) step(16'hFFFF, 1'b1, 1'b1, 1'b1, acc);
      release_reset();

      for (int i = 0; i < 17; i++) begin
         step(16'hFFFF, 1'b0, 1'b1, 1'b1, acc);
         chk("rr_seq", acc, i % NREQ);
      end

      step(16'h2000, 1'b0, 1'b1, 1'b1, acc);
      chk("set_ptr14", acc, 13);
      step(16'h2004, 1'b0, 1'b1, 1'b1, acc);
      chk("wrap_grant2", acc, 2);
      step(16'h2000, 1'b0, 1'b1, 1'b1, acc);
      chk("after_wrap13", acc, 13);

      for (int i = 0; i < 10; i++) begin
         step(16'h0020, 1'b1, 1'b1, 1'b1, acc);
         chk("kap_cap", acc, ((i % 5) == 4) ? 5 : NREQ);
      end
      for (int i = 0; i < 5; i++) begin
         step(16'h0000, 1'b1, 1'b1, 1'b1, acc);
         chk("kap_alone", acc, NREQ);
      end

      for (int i = 0; i < 5; i++) begin
         step(16'h0100, 1'b0, 1'b1, 1'b0, acc);
         chk("stall_no_acc", acc, -1);
      end
      step(16'h0100, 1'b0, 1'b1, 1'b1, acc);
      chk("b2b_accept", acc, 8);

      for (int i = 0; i < 3; i++) begin
         step(16'h0300, 1'b1, 1'b0, 1'b1, acc);
         chk("en_off", acc, -1);
      end
      step(16'h0300, 1'b0, 1'b1, 1'b1, acc);
      chk("en_resume", acc, 9);
      step(16'h0100, 1'b0, 1'b1, 1'b1, acc);
      chk("en_resume2", acc, 8);

      step(16'h0008, 1'b0, 1'b1, 1'b0, acc);
      pulse_reset();
      repeat (2) step(16'hFFFF, 1'b1, 1'b1, 1'b1, acc);
      release_reset();
      step(16'h1008, 1'b0, 1'b1, 1'b1, acc);
      chk("post_rst_grant", acc, 3);

      rv = '0;
      rk = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NREQ; b++) begin
            if (!rv[b] && $urandom_range(0, 7) == 0) rv[b] = 1'b1;
         end
         if (!rk && $urandom_range(0, 3) == 0) rk = 1'b1;
         step(rv, rk, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), acc);
         if (acc == NREQ) rk = 1'b0;
         else if (acc >= 0) rv[acc] = 1'b0;
      end

      repeat (3) step(16'h0000, 1'b0, 1'b1, 1'b1, acc);
      chk("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
